// File: rtl/dqs_burst_gen.sv
// Multi-lane DQS write-burst sequencer: per clk_div cycle emits 4-bit data/tristate nibbles (preamble, toggle burst, postamble).
// Optional macro DQS_BURST_STATS_EN adds the burst_cnt / drop_err statistics outputs.
module dqs_burst_gen #(
  parameter int NUM_LANES = 2,
  parameter int LEN_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       burst_len,
  input  logic [NUM_LANES-1:0]   lane_en,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [4*NUM_LANES-1:0] dqs_data,
  output logic [4*NUM_LANES-1:0] dqs_tri
`ifdef DQS_BURST_STATS_EN
  ,
  output logic [15:0]            burst_cnt,
  output logic                   drop_err
`endif
);

  typedef enum logic [1:0] {IDLE, PRE, BURST, POST} state_t;

  state_t                 state_reg, state_next;
  logic [LEN_W-1:0]       cnt_reg, cnt_next;
  logic [NUM_LANES-1:0]   mask_reg, mask_next;
  logic                   accept;
  logic [3:0]             nib_data, nib_tri;
  logic                   ready_next, busy_next, done_next;
  logic [4*NUM_LANES-1:0] data_next, tri_next;

  // ready is a registered copy of "IDLE, or BURST on its last nibble"
  assign accept = start && ready && (burst_len != '0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mask_next  = mask_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = PRE;
          cnt_next   = burst_len;
          mask_next  = lane_en;
        end
      end
      PRE:  state_next = BURST;
      BURST: begin
        if (cnt_reg > LEN_W'(1)) begin
          cnt_next = cnt_reg - LEN_W'(1);
        end else if (accept) begin
          cnt_next  = burst_len;
          mask_next = lane_en;
        end else begin
          state_next = POST;
        end
      end
      POST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Nibble encoding of the upcoming state; bit0 leaves the serialiser first
  always_comb begin
    nib_data   = 4'b0000;
    nib_tri    = 4'b1111;
    ready_next = 1'b0;
    busy_next  = 1'b1;
    done_next  = 1'b0;
    case (state_next)
      IDLE: begin
        ready_next = 1'b1;
        busy_next  = 1'b0;
      end
      PRE:  nib_tri = 4'b0011;
      BURST: begin
        nib_data   = 4'b0101;
        nib_tri    = 4'b0000;
        ready_next = (cnt_next == LEN_W'(1));
      end
      POST: begin
        nib_tri   = 4'b1110;
        done_next = 1'b1;
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign data_next[4*gi +: 4] = mask_next[gi] ? nib_data : 4'b0000;
      assign tri_next[4*gi +: 4]  = mask_next[gi] ? nib_tri  : 4'b1111;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mask_reg  <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      dqs_data  <= '0;
      dqs_tri   <= '1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mask_reg  <= mask_next;
      ready     <= ready_next;
      busy      <= busy_next;
      done      <= done_next;
      dqs_data  <= data_next;
      dqs_tri   <= tri_next;
    end
  end

`ifdef DQS_BURST_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= '0;
      drop_err  <= 1'b0;
    end else begin
      if (accept) burst_cnt <= burst_cnt + 16'd1;
      if (start && !accept) drop_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dqs_burst_gen.sv
// Directed scoreboard bench for dqs_burst_gen (2 lanes, 4-bit length); checks stats outputs when DQS_BURST_STATS_EN is defined.
module tb_dqs_burst_gen;

  localparam int K_I  = 0;
  localparam int K_P  = 1;
  localparam int K_B  = 2;
  localparam int K_BL = 3;
  localparam int K_O  = 4;

  typedef struct packed {
    logic       rdy;
    logic       bsy;
    logic       dn;
    logic [7:0] d;
    logic [7:0] t;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] burst_len;
  logic [1:0] lane_en;
  logic       ready, busy, done;
  logic [7:0] dqs_data, dqs_tri;
`ifdef DQS_BURST_STATS_EN
  logic [15:0] burst_cnt;
  logic        drop_err;
`endif

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_bcnt = '0;
  logic        exp_drop = 1'b0;

  dqs_burst_gen #(.NUM_LANES(2), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .lane_en   (lane_en),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .dqs_data  (dqs_data),
    .dqs_tri   (dqs_tri)
`ifdef DQS_BURST_STATS_EN
    ,
    .burst_cnt (burst_cnt),
    .drop_err  (drop_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected registered outputs for one cycle of a given phase and lane mask
  function automatic exp_t mk(input int kind, input logic [1:0] m);
    exp_t e;
    logic [3:0] nd, nt;
    e.rdy = 1'b0; e.bsy = 1'b1; e.dn = 1'b0;
    nd = 4'h0; nt = 4'hF;
    case (kind)
      K_I:  begin e.rdy = 1'b1; e.bsy = 1'b0; end
      K_P:  nt = 4'b0011;
      K_B:  begin nd = 4'b0101; nt = 4'b0000; end
      K_BL: begin nd = 4'b0101; nt = 4'b0000; e.rdy = 1'b1; end
      K_O:  begin nt = 4'b1110; e.dn = 1'b1; end
      default: ;
    endcase
    for (int k = 0; k < 2; k++) begin
      e.d[4*k +: 4] = m[k] ? nd : 4'h0;
      e.t[4*k +: 4] = m[k] ? nt : 4'hF;
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check();
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1 at %0t", $time);
    end else begin
      e = q.pop_front();
      cmp("ready", {15'd0, ready}, {15'd0, e.rdy});
      cmp("busy",  {15'd0, busy},  {15'd0, e.bsy});
      cmp("done",  {15'd0, done},  {15'd0, e.dn});
      cmp("dqs_data", {8'd0, dqs_data}, {8'd0, e.d});
      cmp("dqs_tri",  {8'd0, dqs_tri},  {8'd0, e.t});
`ifdef DQS_BURST_STATS_EN
      cmp("burst_cnt", burst_cnt, exp_bcnt);
      cmp("drop_err", {15'd0, drop_err}, {15'd0, exp_drop});
`endif
    end
  endtask

  // Drive inputs for one cycle, queue the expected post-edge outputs, then compare
  task automatic tick(input logic s, input logic [3:0] len, input logic [1:0] en,
                      input int kind, input logic [1:0] m);
    start = s; burst_len = len; lane_en = en;
    q.push_back(mk(kind, m));
    @(posedge clk);
    #1;
    start = 1'b0;
    check();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; burst_len = '0; lane_en = '0;
    #1 rst = 1'b0;
    #2;
    q.push_back(mk(K_I, 2'b00));
    check();
    tick(1'b0, 4'd0, 2'b00, K_I, 2'b00);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b0, 4'd0, 2'b00, K_I, 2'b00);

    // single burst, length 2, both lanes
    exp_bcnt++;
    tick(1'b1, 4'd2, 2'b11, K_P,  2'b11);
    tick(1'b0, 4'd0, 2'b00, K_B,  2'b11);
    tick(1'b0, 4'd0, 2'b00, K_BL, 2'b11);
    tick(1'b0, 4'd0, 2'b00, K_O,  2'b11);
    tick(1'b0, 4'd0, 2'b00, K_I,  2'b00);

    // seamless chain: 3 nibbles then 1 nibble on lane0 only
    exp_bcnt++;
    tick(1'b1, 4'd3, 2'b11, K_P,  2'b11);
    tick(1'b0, 4'd0, 2'b00, K_B,  2'b11);
    tick(1'b0, 4'd0, 2'b00, K_B,  2'b11);
    tick(1'b0, 4'd0, 2'b00, K_BL, 2'b11);
    exp_bcnt++;
    tick(1'b1, 4'd1, 2'b01, K_BL, 2'b01);
    tick(1'b0, 4'd0, 2'b00, K_O,  2'b01);
    tick(1'b0, 4'd0, 2'b00, K_I,  2'b00);

    // zero-length start ignored; start during PRE dropped; lane1-only burst
    exp_drop = 1'b1;
    tick(1'b1, 4'd0, 2'b11, K_I,  2'b00);
    exp_bcnt++;
    tick(1'b1, 4'd1, 2'b10, K_P,  2'b10);
    tick(1'b1, 4'd2, 2'b11, K_BL, 2'b10);
    tick(1'b0, 4'd0, 2'b00, K_O,  2'b10);
    tick(1'b0, 4'd0, 2'b00, K_I,  2'b00);

    // maximum length with a dropped mid-burst start and a dropped start in POST
    exp_bcnt++;
    tick(1'b1, 4'd15, 2'b11, K_P, 2'b11);
    for (int i = 0; i < 14; i++) tick(i == 5, 4'd7, 2'b11, K_B, 2'b11);
    tick(1'b0, 4'd0, 2'b00, K_BL, 2'b11);
    tick(1'b0, 4'd0, 2'b00, K_O,  2'b11);
    tick(1'b1, 4'd2, 2'b11, K_I,  2'b00);
    tick(1'b0, 4'd0, 2'b00, K_I,  2'b00);

    // asynchronous reset in the second BURST cycle
    exp_bcnt++;
    tick(1'b1, 4'd3, 2'b11, K_P, 2'b11);
    tick(1'b0, 4'd0, 2'b00, K_B, 2'b11);
    tick(1'b0, 4'd0, 2'b00, K_B, 2'b11);
    rst = 1'b0;
    exp_bcnt = '0;
    exp_drop = 1'b0;
    #1;
    q.push_back(mk(K_I, 2'b00));
    check();
    tick(1'b0, 4'd0, 2'b00, K_I, 2'b00);
    rst = 1'b1;
    tick(1'b0, 4'd0, 2'b00, K_I, 2'b00);
    tick(1'b0, 4'd0, 2'b00, K_I, 2'b00);
    exp_bcnt++;
    tick(1'b1, 4'd1, 2'b11, K_P,  2'b11);
    tick(1'b0, 4'd0, 2'b00, K_BL, 2'b11);
    tick(1'b0, 4'd0, 2'b00, K_O,  2'b11);
    tick(1'b0, 4'd0, 2'b00, K_I,  2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
